// File: rtl/loader_pkg.sv
// Shared types and helpers for the program loader.
package loader_pkg;

  // Loader FSM states.
  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    BURST,
    RUN,
    ERROR
  } ld_state_t;

  // Shortest legal image: start address plus one (instruction, data) pair.
  localparam int unsigned MIN_LEN = 3;

  // An image is legal when it is odd-sized (address + whole pairs) and not too short.
  function automatic logic len_ok(input int unsigned l);
    return (l[0] == 1'b1) && (l >= MIN_LEN);
  endfunction

endpackage

// File: rtl/loader_buf.sv
// Image buffer: DEPTH x 8 RAM with synchronous write and asynchronous read, no reset.
module loader_buf
  import loader_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [IW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Store an accepted source byte.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/program_loader.sv
// Collects a program image over valid/ready, then plays it into the core as one
// gap-free burst and releases the core with start.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH) + 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic       proc_rst_n,
  output logic [7:0] proc_data,
  output logic       proc_start,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned IW = AW - 1;
  localparam logic [AW-1:0] DepthL = AW'(DEPTH);

  ld_state_t     state_q, state_d;
  logic [AW-1:0] len_q, len_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          xfer;
  logic [IW-1:0] raddr;
  logic [7:0]    rdata;

  logic          proc_rst_n_q;
  logic          proc_start_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;

  // Ready depends only on state and fill level, never on source inputs.
  always_comb begin
    unique case (state_q)
      IDLE:    in_ready = 1'b1;
      COLLECT: in_ready = (len_q < DepthL);
      default: in_ready = 1'b0;
    endcase
  end

  assign xfer = in_valid && in_ready;

  // Next-state and counter update.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE, COLLECT: begin
        if (xfer) begin
          len_d = len_q + 1'b1;
          if (in_last) begin
            idx_d   = '0;
            state_d = len_ok(32'(len_q) + 32'd1) ? BURST : ERROR;
          end else begin
            state_d = COLLECT;
          end
        end else if (state_q == COLLECT && len_q == DepthL) begin
          // Buffer full and no end-of-image marker seen.
          state_d = ERROR;
        end
      end
      BURST: begin
        if (idx_q == len_q - 1'b1) begin
          idx_d   = '0;
          state_d = RUN;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      RUN, ERROR: begin
        if (clear) begin
          len_d   = '0;
          idx_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        len_d   = '0;
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and registered status flags; flags follow the next state so
  // they line up with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      len_q        <= '0;
      idx_q        <= '0;
      proc_rst_n_q <= 1'b0;
      proc_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      proc_rst_n_q <= (state_d == BURST) || (state_d == RUN);
      proc_start_q <= (state_d == RUN);
      busy_q       <= (state_d == COLLECT) || (state_d == BURST);
      done_q       <= (state_d == RUN);
      err_q        <= (state_d == ERROR);
    end
  end

  // Burst walks the buffer; RUN parks on byte 0 (entry address).
  assign raddr = (state_q == BURST) ? idx_q[IW-1:0] : '0;

  loader_buf #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_buf (
    .clk   (clk),
    .we    (xfer),
    .waddr (len_q[IW-1:0]),
    .wdata (in_data),
    .raddr (raddr),
    .rdata (rdata)
  );

  // Core data is forced to zero whenever the core is not being fed or running.
  always_comb begin
    proc_data = 8'h00;
    if (state_q == BURST || state_q == RUN) begin
      proc_data = rdata;
    end
  end

  assign proc_rst_n = proc_rst_n_q;
  assign proc_start = proc_start_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
